// File: rtl/sync_ram_bw.sv
// ---------------------------------------------------------------------------
// sync_ram_bw
//   Single-port synchronous RAM with per-byte write enables, selectable
//   read-during-write behaviour and an optional second output register.
//   Written so that FPGA tools can infer a block RAM from it.
//
// Parameters
//   WORD_WIDTH : data width in bits (multiple of 8)
//   ADDR_WIDTH : address width, depth = 2**ADDR_WIDTH words
//   READ_MODE  : 0 = write-first, 1 = read-first, 2 = no-change
//   OUT_REG    : 1 adds a second output stage (read latency 2)
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset of the output pipeline only
//   en         : access enable
//   we         : byte write enables, bit i covers din[8i+7:8i]
//   addr       : word address
//   din        : write data
//   dout       : read data (qualify with dout_valid)
//   dout_valid : one-cycle pulse per read word presented on dout
// ---------------------------------------------------------------------------
module sync_ram_bw #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int READ_MODE  = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [WORD_WIDTH/8-1:0] we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [WORD_WIDTH-1:0]   din,
  output logic [WORD_WIDTH-1:0]   dout,
  output logic                    dout_valid
);

  localparam int NB_BYTES = WORD_WIDTH / 8;
  localparam int DEPTH    = 2 ** ADDR_WIDTH;

  // Storage array; deliberately never reset so it maps onto block RAM.
  logic [WORD_WIDTH-1:0] mem_q [DEPTH];

  logic [WORD_WIDTH-1:0] rd_word_s;
  logic [WORD_WIDTH-1:0] merged_word_s;
  logic [WORD_WIDTH-1:0] d1_d, d1_q;
  logic                  v1_d, v1_q;

  assign rd_word_s = mem_q[addr];

  // Byte-lane merge of the incoming write onto the pre-edge word.
  always_comb begin
    merged_word_s = rd_word_s;
    for (int i = 0; i < NB_BYTES; i++) begin
      if (we[i]) begin
        merged_word_s[8*i +: 8] = din[8*i +: 8];
      end else begin
        merged_word_s[8*i +: 8] = rd_word_s[8*i +: 8];
      end
    end
  end

  // Array write port; writes proceed even while rst is high.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < NB_BYTES; i++) begin
        if (we[i]) begin
          mem_q[addr][8*i +: 8] <= din[8*i +: 8];
        end
      end
    end
  end

  // Stage-1 next state: read data selection per read-during-write mode.
  always_comb begin
    d1_d = d1_q;
    v1_d = 1'b0;
    if (rst) begin
      d1_d = {WORD_WIDTH{1'b0}};
      v1_d = 1'b0;
    end else if (en) begin
      if (we == {NB_BYTES{1'b0}}) begin
        d1_d = rd_word_s;
        v1_d = 1'b1;
      end else begin
        case (READ_MODE)
          32'sd0: begin
            d1_d = merged_word_s;
            v1_d = 1'b1;
          end
          32'sd1: begin
            d1_d = rd_word_s;
            v1_d = 1'b1;
          end
          default: begin
            // No-change: a write produces no read word.
            d1_d = d1_q;
            v1_d = 1'b0;
          end
        endcase
      end
    end else begin
      d1_d = d1_q;
      v1_d = 1'b0;
    end
  end

  // Stage-1 registers.
  always_ff @(posedge clk) begin
    d1_q <= d1_d;
    v1_q <= v1_d;
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [WORD_WIDTH-1:0] d2_d, d2_q;
    logic                  v2_d, v2_q;

    // Stage-2 next state: capture only valid stage-1 words.
    always_comb begin
      d2_d = d2_q;
      v2_d = 1'b0;
      if (rst) begin
        d2_d = {WORD_WIDTH{1'b0}};
        v2_d = 1'b0;
      end else if (v1_q) begin
        d2_d = d1_q;
        v2_d = 1'b1;
      end else begin
        d2_d = d2_q;
        v2_d = 1'b0;
      end
    end

    // Stage-2 registers.
    always_ff @(posedge clk) begin
      d2_q <= d2_d;
      v2_q <= v2_d;
    end

    assign dout       = d2_q;
    assign dout_valid = v2_q;
  end else begin : g_no_out_reg
    assign dout       = d1_q;
    assign dout_valid = v1_q;
  end

endmodule

// File: tb/tb_sync_ram_bw.sv
// ---------------------------------------------------------------------------
// tb_sync_ram_bw
//   Directed bench for sync_ram_bw. Five instances share one stimulus bus:
//   write-first, read-first and no-change (OUT_REG=0), write-first with
//   OUT_REG=1, and a 16-word instance for the full-depth sweep.
// ---------------------------------------------------------------------------
module tb_sync_ram_bw;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  we;
  logic [9:0]  addr;
  logic [31:0] din;

  logic [31:0] dout_wf, dout_rf, dout_nc, dout_or, dout_sw;
  logic        val_wf,  val_rf,  val_nc,  val_or,  val_sw;

  int pass_cnt  = 0;
  int total_cnt = 0;

  sync_ram_bw #(.WORD_WIDTH(32), .ADDR_WIDTH(10), .READ_MODE(0), .OUT_REG(0)) u_wf (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din),
    .dout(dout_wf), .dout_valid(val_wf));
  sync_ram_bw #(.WORD_WIDTH(32), .ADDR_WIDTH(10), .READ_MODE(1), .OUT_REG(0)) u_rf (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din),
    .dout(dout_rf), .dout_valid(val_rf));
  sync_ram_bw #(.WORD_WIDTH(32), .ADDR_WIDTH(10), .READ_MODE(2), .OUT_REG(0)) u_nc (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din),
    .dout(dout_nc), .dout_valid(val_nc));
  sync_ram_bw #(.WORD_WIDTH(32), .ADDR_WIDTH(10), .READ_MODE(0), .OUT_REG(1)) u_or (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din),
    .dout(dout_or), .dout_valid(val_or));
  sync_ram_bw #(.WORD_WIDTH(32), .ADDR_WIDTH(4), .READ_MODE(0), .OUT_REG(0)) u_sw (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr[3:0]), .din(din),
    .dout(dout_sw), .dout_valid(val_sw));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; we = 4'h0; addr = 10'd0; din = 32'h0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total_cnt++;
      if (dout_wf !== 32'h0 || val_wf !== 1'b0) $display("FAIL reset_wf: got %h/%b required 00000000/0", dout_wf, val_wf);
      else pass_cnt++;
      total_cnt++;
      if (dout_or !== 32'h0 || val_or !== 1'b0) $display("FAIL reset_or: got %h/%b required 00000000/0", dout_or, val_or);
      else pass_cnt++;
    end
    rst = 1'b0; en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total_cnt++;
      if (dout_wf !== 32'h0 || val_wf !== 1'b0 || dout_or !== 32'h0 || val_or !== 1'b0)
        $display("FAIL idle_after_reset: got wf %h/%b or %h/%b required 0/0", dout_wf, val_wf, dout_or, val_or);
      else pass_cnt++;
    end
  endtask

  task automatic test_byte_lanes();
    en = 1'b1; we = 4'hF; addr = 10'd5; din = 32'h11223344;
    tick();
    total_cnt++;
    if (dout_wf !== 32'h11223344 || val_wf !== 1'b1) $display("FAIL full_write_wf: got %h/%b required 11223344/1", dout_wf, val_wf);
    else pass_cnt++;
    we = 4'b0101; din = 32'hAABBCCDD;
    tick();
    total_cnt++;
    if (dout_wf !== 32'h11BB33DD || val_wf !== 1'b1) $display("FAIL partial_write_wf: got %h/%b required 11BB33DD/1", dout_wf, val_wf);
    else pass_cnt++;
    we = 4'h0; din = 32'h0;
    tick();
    total_cnt++;
    if (dout_wf !== 32'h11BB33DD || val_wf !== 1'b1) $display("FAIL lane_read: got %h/%b required 11BB33DD/1", dout_wf, val_wf);
    else pass_cnt++;
    en = 1'b0;
    tick();
    total_cnt++;
    if (dout_wf !== 32'h11BB33DD || val_wf !== 1'b0) $display("FAIL hold_idle: got %h/%b required 11BB33DD/0", dout_wf, val_wf);
    else pass_cnt++;
  endtask

  task automatic test_read_modes();
    en = 1'b1; we = 4'hF; addr = 10'd7; din = 32'h0000FFFF;
    tick();
    // The no-change instance still holds the word from the earlier lane read.
    total_cnt++;
    if (dout_nc !== 32'h11BB33DD || val_nc !== 1'b0) $display("FAIL nc_preload: got %h/%b required 11BB33DD/0", dout_nc, val_nc);
    else pass_cnt++;
    din = 32'h12345678;
    tick();
    total_cnt++;
    if (dout_wf !== 32'h12345678 || val_wf !== 1'b1) $display("FAIL rdw_write_first: got %h/%b required 12345678/1", dout_wf, val_wf);
    else pass_cnt++;
    total_cnt++;
    if (dout_rf !== 32'h0000FFFF || val_rf !== 1'b1) $display("FAIL rdw_read_first: got %h/%b required 0000FFFF/1", dout_rf, val_rf);
    else pass_cnt++;
    total_cnt++;
    if (dout_nc !== 32'h11BB33DD || val_nc !== 1'b0) $display("FAIL rdw_no_change: got %h/%b required 11BB33DD/0", dout_nc, val_nc);
    else pass_cnt++;
    we = 4'h0;
    tick();
    total_cnt++;
    if (dout_wf !== 32'h12345678 || val_wf !== 1'b1) $display("FAIL wr_then_rd_wf: got %h/%b required 12345678/1", dout_wf, val_wf);
    else pass_cnt++;
    total_cnt++;
    if (dout_rf !== 32'h12345678 || val_rf !== 1'b1) $display("FAIL wr_then_rd_rf: got %h/%b required 12345678/1", dout_rf, val_rf);
    else pass_cnt++;
    total_cnt++;
    if (dout_nc !== 32'h12345678 || val_nc !== 1'b1) $display("FAIL wr_then_rd_nc: got %h/%b required 12345678/1", dout_nc, val_nc);
    else pass_cnt++;
    en = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_word;
    int          valid_seen;
    en = 1'b1; we = 4'hF;
    for (int i = 0; i < 4; i++) begin
      addr = 10'(i);
      din  = 32'hA0 + 32'(i);
      tick();
    end
    en = 1'b0; we = 4'h0;
    tick();
    tick();
    valid_seen = 0;
    en = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      if (e <= 4) begin
        en = 1'b1; addr = 10'(e - 1);
      end else begin
        en = 1'b0;
      end
      tick();
      if (val_or === 1'b1) valid_seen++;
      if (e >= 2 && e <= 5) begin
        exp_word = 32'hA0 + 32'(e - 2);
        total_cnt++;
        if (dout_or !== exp_word || val_or !== 1'b1) $display("FAIL pipe_edge%0d: got %h/%b required %h/1", e, dout_or, val_or, exp_word);
        else pass_cnt++;
      end else if (e == 1) begin
        total_cnt++;
        if (val_or !== 1'b0) $display("FAIL pipe_latency: got valid %b required 0", val_or);
        else pass_cnt++;
      end else begin
        total_cnt++;
        if (dout_or !== 32'hA3 || val_or !== 1'b0) $display("FAIL pipe_drain: got %h/%b required 000000A3/0", dout_or, val_or);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (valid_seen !== 4) $display("FAIL pipe_valid_count: got %0d required 4", valid_seen);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    en = 1'b1; we = 4'h0; addr = 10'd1;
    tick();
    rst = 1'b1; we = 4'hF; addr = 10'd9; din = 32'hCAFEF00D;
    tick();
    total_cnt++;
    if (dout_or !== 32'h0 || val_or !== 1'b0) $display("FAIL mid_reset_or: got %h/%b required 00000000/0", dout_or, val_or);
    else pass_cnt++;
    rst = 1'b0; en = 1'b0; we = 4'h0;
    for (int c = 0; c < 2; c++) begin
      tick();
      total_cnt++;
      if (dout_or !== 32'h0 || val_or !== 1'b0) $display("FAIL no_stale_valid: got %h/%b required 00000000/0", dout_or, val_or);
      else pass_cnt++;
    end
    en = 1'b1; addr = 10'd9;
    tick();
    total_cnt++;
    if (val_or !== 1'b0) $display("FAIL rst_write_latency: got valid %b required 0", val_or);
    else pass_cnt++;
    en = 1'b0;
    tick();
    total_cnt++;
    if (dout_or !== 32'hCAFEF00D || val_or !== 1'b1) $display("FAIL write_during_rst: got %h/%b required CAFEF00D/1", dout_or, val_or);
    else pass_cnt++;
  endtask

  task automatic test_sweep();
    logic [31:0] exp_word;
    en = 1'b1; we = 4'hF;
    for (int i = 0; i < 16; i++) begin
      addr = 10'(i);
      din  = 32'(i) ^ 32'h5A5A5A5A;
      tick();
    end
    we = 4'h0;
    for (int i = 0; i < 16; i++) begin
      addr = 10'(i);
      tick();
      exp_word = 32'(i) ^ 32'h5A5A5A5A;
      total_cnt++;
      if (dout_sw !== exp_word || val_sw !== 1'b1) $display("FAIL sweep_addr%0d: got %h/%b required %h/1", i, dout_sw, val_sw, exp_word);
      else pass_cnt++;
    end
    addr = 10'h00F;
    tick();
    total_cnt++;
    if (dout_sw !== 32'h5A5A5A55) $display("FAIL wrap_top: got %h required 5A5A5A55", dout_sw);
    else pass_cnt++;
    addr = 10'h010;
    tick();
    total_cnt++;
    if (dout_sw !== 32'h5A5A5A5A || val_sw !== 1'b1) $display("FAIL wrap_zero: got %h/%b required 5A5A5A5A/1", dout_sw, val_sw);
    else pass_cnt++;
    en = 1'b0;
    tick();
    total_cnt++;
    if (val_sw !== 1'b0) $display("FAIL sweep_idle: got valid %b required 0", val_sw);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; we = 4'h0; addr = 10'd0; din = 32'h0;
    test_reset();
    test_byte_lanes();
    test_read_modes();
    test_back_to_back();
    test_reset_mid_op();
    test_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
